// File: rtl/reg_file_sb_pkg.sv
// Shared register-file sizing, write-port bundle and index helpers.
package reg_file_sb_pkg;
  localparam int WORD_SIZE     = 32;
  localparam int REG_INDEX     = 5;
  localparam int REG_FILE_SIZE = 32;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [REG_INDEX-1:0] idx_t;
  typedef logic [REG_FILE_SIZE-1:0] mask_t;

  typedef struct packed {
    logic  en;
    idx_t  num;
    word_t val;
  } wr_t;

  function automatic logic idx_valid(input idx_t n);
    return int'(n) < REG_FILE_SIZE;
  endfunction

  function automatic mask_t onehot(input idx_t n);
    return mask_t'(1) << n;
  endfunction
endpackage

// File: rtl/reg_file_sb_rd_port.sv
// One combinational read port: register/busy lookup with optional same-cycle write bypass.
module reg_file_rd_port
  import reg_file_sb_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  idx_t                           rd_num_i,
  input  word_t [REG_FILE_SIZE-1:0]      regs_i,
  input  mask_t                          busy_i,
  input  wr_t                            wa_i,
  input  wr_t                            wb_i,
  output word_t                          rd_val_o,
  output logic                           rd_busy_o
);
  always_comb begin
    rd_val_o  = '0;
    rd_busy_o = 1'b0;
    if (idx_valid(rd_num_i) && !(ZERO_REG && rd_num_i == '0)) begin
      rd_val_o  = regs_i[rd_num_i];
      rd_busy_o = busy_i[rd_num_i];
      // Write enables arrive pre-qualified, so a hit here is always a real write; A has priority.
      if (BYPASS) begin
        if (wa_i.en && wa_i.num == rd_num_i) begin
          rd_val_o  = wa_i.val;
          rd_busy_o = 1'b0;
        end else if (wb_i.en && wb_i.num == rd_num_i) begin
          rd_val_o  = wb_i.val;
          rd_busy_o = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with busy scoreboard; reads and claim_ok are combinational,
// state updates on the next edge; a refused claim (claim_ok=0) leaves state untouched for retry.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_RD   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          reset_enable_i,
  input  logic [NUM_RD*REG_INDEX-1:0]   rd_num_i,
  output logic [NUM_RD*WORD_SIZE-1:0]   rd_val_o,
  output logic [NUM_RD-1:0]             rd_busy_o,
  input  logic                          wa_enable_i,
  input  logic [REG_INDEX-1:0]          wa_num_i,
  input  logic [WORD_SIZE-1:0]          wa_val_i,
  input  logic                          wb_enable_i,
  input  logic [REG_INDEX-1:0]          wb_num_i,
  input  logic [WORD_SIZE-1:0]          wb_val_i,
  input  logic                          claim_enable_i,
  input  logic [REG_INDEX-1:0]          claim_num_i,
  output logic                          claim_ok_o,
  output logic [REG_INDEX:0]            busy_count_o
);
  word_t [REG_FILE_SIZE-1:0] regs_q;
  mask_t                     busy_q, busy_d, clr_mask, set_mask;
  logic [REG_INDEX:0]        busy_count_q, busy_count_d, n_clr;
  logic                      n_set;
  wr_t                       wa, wb;

  function automatic logic wr_ok(input idx_t n);
    return idx_valid(n) && !(ZERO_REG && n == '0);
  endfunction

  assign wa = '{en: wa_enable_i && wr_ok(wa_num_i), num: wa_num_i, val: wa_val_i};
  assign wb = '{en: wb_enable_i && wr_ok(wb_num_i), num: wb_num_i, val: wb_val_i};

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wa.en) clr_mask = clr_mask | onehot(wa.num);
    if (wb.en) clr_mask = clr_mask | onehot(wb.num);
    claim_ok_o = claim_enable_i && idx_valid(claim_num_i) &&
                 (!busy_q[claim_num_i] ||
                  (wa.en && wa.num == claim_num_i) ||
                  (wb.en && wb.num == claim_num_i));
    if (claim_ok_o && wr_ok(claim_num_i)) set_mask = onehot(claim_num_i);
    // Claim wins over a clear of the same bit, so that bit is excluded from the clear count.
    busy_d       = (busy_q & ~clr_mask) | set_mask;
    n_clr        = (REG_INDEX+1)'($countones(busy_q & clr_mask & ~set_mask));
    n_set        = |(set_mask & ~busy_q);
    busy_count_d = busy_count_q + {{REG_INDEX{1'b0}}, n_set} - n_clr;
  end

  always_ff @(posedge clk_i or posedge reset_enable_i) begin
    if (reset_enable_i) begin
      regs_q       <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (wb.en) regs_q[wb.num] <= wb.val;
      if (wa.en) regs_q[wa.num] <= wa.val;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count_o = busy_count_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(.ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd (
      .rd_num_i (rd_num_i[k*REG_INDEX +: REG_INDEX]),
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .wa_i     (wa),
      .wb_i     (wb),
      .rd_val_o (rd_val_o[k*WORD_SIZE +: WORD_SIZE]),
      .rd_busy_o(rd_busy_o[k])
    );
  end
endmodule
